// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer, clocked from the PLL reference clock.
// It pulses the PLL reset, then waits for lock with a timeout and bounded retries.
// Lock must then hold steadily before the downstream system reset is released.
// Optional feature macro: PLL_SEQ_LOSS_MON_EN.
//   Defined:   losing lock in RUN restarts the whole sequence.
//   Undefined: RUN ignores lock; only restart or reset_n leaves RUN.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 2700000,
    parameter int unsigned LOCK_STABLE  = 27000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_lock,
    input  logic       restart,
    output logic       pll_reset,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_count
);

    localparam int unsigned MaxA      = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MaxCycles = (MaxA > LOCK_STABLE) ? MaxA : LOCK_STABLE;
    localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

    localparam logic [CntW-1:0] LoadRst    = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0] LoadTo     = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0] LoadStable = CntW'(LOCK_STABLE - 1);
    localparam logic [3:0]      MaxRetry   = 4'(MAX_RETRY);

    localparam logic [2:0] StResetPll = 3'd0;
    localparam logic [2:0] StWaitLock = 3'd1;
    localparam logic [2:0] StStable   = 3'd2;
    localparam logic [2:0] StRun      = 3'd3;
    localparam logic [2:0] StFail     = 3'd4;

    logic [1:0]      sync_q;
    logic            lock_s;
    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      retry_q, retry_d;
    logic            pll_reset_q, sys_reset_n_q, ready_q, fail_q;

    assign lock_s = sync_q[1];

    // Two-flop synchronizer; the only consumer of the raw lock input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_lock};
        end
    end

    // Next state: the shared down-counter is reloaded on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        if (restart) begin
            state_d = StResetPll;
            cnt_d   = LoadRst;
            retry_d = 4'd0;
        end else begin
            case (state_q)
                StResetPll: begin
                    if (cnt_q == '0) begin
                        state_d = StWaitLock;
                        cnt_d   = LoadTo;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StWaitLock: begin
                    // Lock wins over a simultaneous timeout.
                    if (lock_s) begin
                        state_d = StStable;
                        cnt_d   = LoadStable;
                    end else if (cnt_q == '0) begin
                        if (retry_q == MaxRetry) begin
                            state_d = StFail;
                        end else begin
                            state_d = StResetPll;
                            cnt_d   = LoadRst;
                            retry_d = retry_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StStable: begin
                    // A lock drop is not a failed attempt: full timeout, retries kept.
                    if (!lock_s) begin
                        state_d = StWaitLock;
                        cnt_d   = LoadTo;
                    end else if (cnt_q == '0) begin
                        state_d = StRun;
                        retry_d = 4'd0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StRun: begin
`ifdef PLL_SEQ_LOSS_MON_EN
                    if (!lock_s) begin
                        state_d = StResetPll;
                        cnt_d   = LoadRst;
                        retry_d = 4'd0;
                    end
`endif
                end
                StFail: begin
                    // Terminal until restart or reset_n.
                end
                default: begin
                    state_d = StResetPll;
                    cnt_d   = LoadRst;
                    retry_d = 4'd0;
                end
            endcase
        end
    end

    // State, counter, retry and Moore outputs decoded from the next state so all change together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StResetPll;
            cnt_q         <= LoadRst;
            retry_q       <= 4'd0;
            pll_reset_q   <= 1'b1;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            pll_reset_q   <= (state_d == StResetPll) || (state_d == StFail);
            sys_reset_n_q <= (state_d == StRun);
            ready_q       <= (state_d == StRun);
            fail_q        <= (state_d == StFail);
        end
    end

    assign pll_reset   = pll_reset_q;
    assign sys_reset_n = sys_reset_n_q;
    assign ready       = ready_q;
    assign fail        = fail_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small dwell parameters.
// Follows PLL_SEQ_LOSS_MON_EN when choosing RUN lock-loss expectations.
module tb_pll_lock_sequencer;

    localparam int unsigned RstCycles   = 4;
    localparam int unsigned LockTimeout = 32;
    localparam int unsigned LockStable  = 8;
    localparam int unsigned MaxRetry    = 2;
    localparam int          Limit       = 200;

`ifdef PLL_SEQ_LOSS_MON_EN
    localparam bit LossMon = 1'b1;
`else
    localparam bit LossMon = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_lock;
    logic       restart;
    logic       pll_reset;
    logic       sys_reset_n;
    logic       ready;
    logic       fail;
    logic [3:0] retry_count;

    int n_tests = 0;
    int n_fail  = 0;

    pll_lock_sequencer #(
        .RST_CYCLES  (RstCycles),
        .LOCK_TIMEOUT(LockTimeout),
        .LOCK_STABLE (LockStable),
        .MAX_RETRY   (MaxRetry)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pll_lock   (pll_lock),
        .restart    (restart),
        .pll_reset  (pll_reset),
        .sys_reset_n(sys_reset_n),
        .ready      (ready),
        .fail       (fail),
        .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig_of(input int sel);
        case (sel)
            0:       return pll_reset;
            1:       return ready;
            default: return fail;
        endcase
    endfunction

    // Count edges until the selected output equals val; capped at Limit.
    task automatic wait_for(input int sel, input logic val, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (sig_of(sel) !== val && n < Limit);
    endtask

    int n;

    initial begin
        reset_n  = 1'b0;
        pll_lock = 1'b0;
        restart  = 1'b0;
        tick();
        tick();
        check_eq("rst_pll_reset", 32'(pll_reset), 32'd1);
        check_eq("rst_sys_reset_n", 32'(sys_reset_n), 32'd0);
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_fail", 32'(fail), 32'd0);
        check_eq("rst_retry", 32'(retry_count), 32'd0);

        // Bring-up: 4-cycle PLL reset, lock 2 cycles later, RUN 10 edges after first sample.
        reset_n = 1'b1;
        wait_for(0, 1'b0, n);
        check_eq("t1_rst_width", 32'(n), 32'd4);
        tick();
        tick();
        pll_lock = 1'b1;
        tick();
        wait_for(1, 1'b1, n);
        check_eq("t1_lock_to_ready", 32'(n), 32'd10);
        check_eq("t1_sys_reset_n", 32'(sys_reset_n), 32'd1);
        check_eq("t1_retry", 32'(retry_count), 32'd0);
        check_eq("t1_pll_reset", 32'(pll_reset), 32'd0);

        // Restart in RUN on the same edge a lock loss would act.
        pll_lock = 1'b0;
        tick();
        tick();
        check_eq("t5b_ready_before", 32'(ready), 32'd1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_eq("t5b_pll_reset", 32'(pll_reset), 32'd1);
        check_eq("t5b_sys_reset_n", 32'(sys_reset_n), 32'd0);
        check_eq("t5b_ready", 32'(ready), 32'd0);
        check_eq("t5b_retry", 32'(retry_count), 32'd0);
        wait_for(0, 1'b0, n);
        check_eq("t5b_rst_width", 32'(n), 32'd4);

        // One timeout, then a one-cycle lock glitch in STABLE.
        wait_for(0, 1'b1, n);
        check_eq("t3_timeout", 32'(n), 32'd32);
        check_eq("t3_retry1", 32'(retry_count), 32'd1);
        wait_for(0, 1'b0, n);
        check_eq("t3_rst_width", 32'(n), 32'd4);
        pll_lock = 1'b1;
        tick();                       // k
        tick();                       // k+1
        tick();                       // k+2: STABLE, count 7
        pll_lock = 1'b0;
        tick();                       // k+3: low sampled once
        pll_lock = 1'b1;
        for (int i = 4; i <= 13; i++) tick();
        check_eq("t3_ready_k13", 32'(ready), 32'd0);
        check_eq("t3_retry_kept", 32'(retry_count), 32'd1);
        tick();                       // k+14
        check_eq("t3_ready_k14", 32'(ready), 32'd1);
        check_eq("t3_retry_clr", 32'(retry_count), 32'd0);

        // Lock loss in RUN.
        pll_lock = 1'b0;
        tick();
        check_eq("t4_sys_m0", 32'(sys_reset_n), 32'd1);
        tick();
        check_eq("t4_sys_m1", 32'(sys_reset_n), 32'd1);
        tick();
        check_eq("t4_sys_m2", 32'(sys_reset_n), LossMon ? 32'd0 : 32'd1);
        check_eq("t4_pll_reset_m2", 32'(pll_reset), LossMon ? 32'd1 : 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check_eq("t4_ready_late", 32'(ready), LossMon ? 32'd0 : 32'd1);

        // No lock at all: three attempts, then FAIL.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        for (int p = 0; p < 3; p++) begin
            wait_for(0, 1'b0, n);
            check_eq("t2_pulse_width", 32'(n), 32'd4);
            check_eq("t2_retry_pulse", 32'(retry_count), 32'(p));
            if (p < 2) begin
                wait_for(0, 1'b1, n);
                check_eq("t2_gap", 32'(n), 32'd32);
            end else begin
                wait_for(2, 1'b1, n);
                check_eq("t2_to_fail", 32'(n), 32'd32);
            end
        end
        check_eq("t2_fail_pll_reset", 32'(pll_reset), 32'd1);
        check_eq("t2_fail_retry", 32'(retry_count), 32'd2);
        for (int i = 0; i < 10; i++) tick();
        check_eq("t2_fail_held", 32'(fail), 32'd1);
        check_eq("t2_pll_reset_held", 32'(pll_reset), 32'd1);
        check_eq("t2_sys_held", 32'(sys_reset_n), 32'd0);

        // Restart out of FAIL.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_eq("t5a_fail", 32'(fail), 32'd0);
        check_eq("t5a_retry", 32'(retry_count), 32'd0);
        check_eq("t5a_pll_reset", 32'(pll_reset), 32'd1);

        // Asynchronous reset in the middle of WAIT_LOCK.
        wait_for(0, 1'b0, n);
        wait_for(0, 1'b1, n);
        wait_for(0, 1'b0, n);
        tick();
        tick();
        tick();
        check_eq("t6_retry_before", 32'(retry_count), 32'd1);
        check_eq("t6_pll_reset_before", 32'(pll_reset), 32'd0);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("t6_pll_reset", 32'(pll_reset), 32'd1);
        check_eq("t6_retry", 32'(retry_count), 32'd0);
        check_eq("t6_sys_reset_n", 32'(sys_reset_n), 32'd0);
        check_eq("t6_ready", 32'(ready), 32'd0);
        check_eq("t6_fail", 32'(fail), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
